// File: rtl/cfir_pkg.sv
// CIC compensation FIR: shared constants, coefficient table, FSM state type.
// Coefficients are S[18,17], symmetric around tap 10, sum ~1.078.
package cfir_pkg;

  localparam int WIN    = 16;
  localparam int WOUT   = 16;
  localparam int COEF_W = 18;
  localparam int NTAPS  = 21;
  localparam int WACC   = 40;

  localparam logic signed [COEF_W-1:0] COEF [NTAPS] = '{
    -18'sd120,   18'sd210,  -18'sd340,   18'sd520,
    -18'sd780,   18'sd1150, -18'sd1720,  18'sd2700,
    -18'sd5000,  18'sd14000, 18'sd120000,
     18'sd14000, -18'sd5000,  18'sd2700, -18'sd1720,
     18'sd1150,  -18'sd780,   18'sd520,  -18'sd340,
     18'sd210,   -18'sd120
  };

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    OUT  = 2'd2
  } cfir_state_t;

endpackage

// File: rtl/cfir_sbuf.sv
// Circular sample buffer with one write port and two taps
// addressed as offsets back from the newest sample.
module cfir_sbuf #(
  parameter int Win   = 16,
  parameter int Ntaps = 21,
  parameter int AW    = $clog2(Ntaps)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           we_i,
  input  logic [Win-1:0] wdata_i,
  input  logic [AW-1:0]  offa_i,
  input  logic [AW-1:0]  offb_i,
  output logic [Win-1:0] rda_o,
  output logic [Win-1:0] rdb_o
);

  logic [Win-1:0] mem_q [Ntaps];
  logic [AW-1:0]  wr_q;
  logic [AW-1:0]  wr_d;
  logic [AW-1:0]  newest;

  function automatic logic [AW-1:0] tap_addr(
    input logic [AW-1:0] nw,
    input logic [AW-1:0] off
  );
    logic [AW:0] s;
    s = {1'b0, nw} + (AW+1)'(Ntaps) - {1'b0, off};
    if (s >= (AW+1)'(Ntaps))
      s = s - (AW+1)'(Ntaps);
    return s[AW-1:0];
  endfunction

  assign wr_d = (wr_q == AW'(Ntaps-1)) ? '0
              : wr_q + AW'(1);

  assign newest = (wr_q == '0) ? AW'(Ntaps-1)
                : wr_q - AW'(1);

  assign rda_o = mem_q[tap_addr(newest, offa_i)];
  assign rdb_o = mem_q[tap_addr(newest, offb_i)];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q <= '0;
      for (int i = 0; i < Ntaps; i++)
        mem_q[i] <= '0;
    end else if (we_i) begin
      mem_q[wr_q] <= wdata_i;
      wr_q        <= wr_d;
    end
  end

endmodule

// File: rtl/cfir_dec.sv
// Folded symmetric FIR with one time-shared multiplier, decimation
// phase counter, round-half-up and saturation to S[Wout,Wout-1].
module cfir_dec
  import cfir_pkg::*;
#(
  parameter int Win   = WIN,
  parameter int Wout  = WOUT,
  parameter int Wcoef = COEF_W,
  parameter int Ntaps = NTAPS,
  parameter int D     = 2,
  parameter int Wacc  = WACC
) (
  input  logic            clk,
  input  logic            ic_rst_n,
  input  logic [Win-1:0]  id_data,
  input  logic            ic_val_data,
  output logic [Wout-1:0] od_data,
  output logic            oc_val_data,
  output logic            oc_ovr
);

  localparam int M  = (Ntaps + 1) / 2;
  localparam int KW = $clog2(M);
  localparam int PW = (D > 1) ? $clog2(D) : 1;
  localparam int AW = $clog2(Ntaps);
  localparam int PB = Win + 1 + Wcoef;

  cfir_state_t state_q, state_d;
  logic [KW-1:0]   k_q, k_d;
  logic [PW-1:0]   phase_q, phase_d;
  logic [Wacc-1:0] acc_q, acc_d;
  logic [Wout-1:0] od_q, od_d;
  logic            val_q, val_d;
  logic            ovr_q, ovr_d;
  logic            we;

  logic [AW-1:0]   offa, offb;
  logic [Win-1:0]  rda, rdb;

  assign offa = AW'(k_q);
  assign offb = AW'(Ntaps-1) - AW'(k_q);

  cfir_sbuf #(
    .Win   (Win),
    .Ntaps (Ntaps),
    .AW    (AW)
  ) u_sbuf (
    .clk     (clk),
    .rst_n   (ic_rst_n),
    .we_i    (we),
    .wdata_i (id_data),
    .offa_i  (offa),
    .offb_i  (offb),
    .rda_o   (rda),
    .rdb_o   (rdb)
  );

  logic              center;
  logic signed [Win:0]  pre;
  logic signed [PB-1:0] prod;
  logic [Wacc-1:0]      prod_x;

  // Centre tap has no mirror partner, so its second operand is zeroed.
  assign center = (k_q == KW'(M-1));
  assign pre = $signed({rda[Win-1], rda})
             + (center ? '0 : $signed({rdb[Win-1], rdb}));
  assign prod   = pre * COEF[k_q];
  assign prod_x = {{(Wacc-PB){prod[PB-1]}}, prod};

  logic signed [Wacc-1:0] rnd, shf;
  logic [Wout-1:0]        y;
  logic [Wacc-Wout:0]     hi;

  assign rnd = $signed(acc_q) + $signed(Wacc'(1) << (Wcoef-2));
  assign shf = rnd >>> (Wcoef-1);
  assign hi  = shf[Wacc-1:Wout-1];

  always_comb begin
    y = shf[Wout-1:0];
    if (!(hi == '0 || hi == '1))
      y = shf[Wacc-1] ? {1'b1, {(Wout-1){1'b0}}}
                      : {1'b0, {(Wout-1){1'b1}}};
  end

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    phase_d = phase_q;
    acc_d   = acc_q;
    od_d    = od_q;
    val_d   = 1'b0;
    ovr_d   = ovr_q;
    we      = 1'b0;
    if (ic_val_data && state_q != IDLE)
      ovr_d = 1'b1;
    unique case (1'b1)
      (state_q == IDLE): begin
        if (ic_val_data) begin
          we = 1'b1;
          if (phase_q == PW'(D-1)) begin
            phase_d = '0;
            state_d = MAC;
            k_d     = '0;
            acc_d   = '0;
          end else begin
            phase_d = phase_q + PW'(1);
          end
        end
      end
      (state_q == MAC): begin
        acc_d = acc_q + prod_x;
        if (center)
          state_d = OUT;
        else
          k_d = k_q + KW'(1);
      end
      (state_q == OUT): begin
        od_d    = y;
        val_d   = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge ic_rst_n) begin
    if (!ic_rst_n) begin
      state_q <= IDLE;
      k_q     <= '0;
      phase_q <= '0;
      acc_q   <= '0;
      od_q    <= '0;
      val_q   <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      phase_q <= phase_d;
      acc_q   <= acc_d;
      od_q    <= od_d;
      val_q   <= val_d;
      ovr_q   <= ovr_d;
    end
  end

  assign od_data     = od_q;
  assign oc_val_data = val_q;
  assign oc_ovr      = ovr_q;

endmodule

// File: tb/tb_cfir_dec.sv
// Bench for cfir_dec: D=1 and D=2 instances share one input stream,
// each checked against a direct-form reference with its own scoreboard.
module tb_cfir_dec;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] din = '0;
  logic        vin = 1'b0;
  logic [15:0] od1, od2;
  logic        vld1, vld2;
  logic        ovr1, ovr2;

  always #5 clk = ~clk;

  cfir_dec #(.D(1)) u_d1 (
    .clk(clk), .ic_rst_n(rst_n), .id_data(din),
    .ic_val_data(vin), .od_data(od1),
    .oc_val_data(vld1), .oc_ovr(ovr1)
  );

  cfir_dec #(.D(2)) u_d2 (
    .clk(clk), .ic_rst_n(rst_n), .id_data(din),
    .ic_val_data(vin), .od_data(od2),
    .oc_val_data(vld2), .oc_ovr(ovr2)
  );

  int C [21] = '{
    -120, 210, -340, 520, -780, 1150, -1720, 2700, -5000, 14000,
    120000,
    14000, -5000, 2700, -1720, 1150, -780, 520, -340, 210, -120
  };

  typedef struct {
    logic [15:0] y;
    int          cyc;
  } exp_t;

  exp_t q1 [$];
  exp_t q2 [$];
  exp_t e1, e2;

  int hist [2][21];
  int phase [2];
  int free_at [2];
  bit ovr_m [2];

  int cyc = 0;
  int nvec = 0;
  int nerr = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] calc(input int i);
    longint acc = 0;
    longint r;
    for (int j = 0; j < 21; j++)
      acc += longint'(C[j]) * longint'(hist[i][j]);
    r = (acc + 64'sd65536) >>> 17;
    if (r > 32767) r = 32767;
    if (r < -32768) r = -32768;
    return 16'(r);
  endfunction

  task automatic model(input logic [15:0] x);
    exp_t e;
    int dv;
    for (int i = 0; i < 2; i++) begin
      dv = (i == 0) ? 1 : 2;
      if (cyc < free_at[i]) begin
        ovr_m[i] = 1'b1;
      end else begin
        for (int j = 20; j > 0; j--)
          hist[i][j] = hist[i][j-1];
        hist[i][0] = int'($signed(x));
        if (phase[i] == dv - 1) begin
          phase[i]   = 0;
          e.y        = calc(i);
          e.cyc      = cyc + 13;
          free_at[i] = cyc + 13;
          if (i == 0) q1.push_back(e);
          else        q2.push_back(e);
        end else begin
          phase[i]++;
        end
      end
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      for (int j = 0; j < 21; j++) hist[i][j] = 0;
      phase[i]   = 0;
      free_at[i] = 0;
      ovr_m[i]   = 1'b0;
    end
    q1.delete();
    q2.delete();
  endtask

  // Called #1 after a rising edge; returns #1 after edge +gap.
  task automatic send(input logic [15:0] x, input int gap);
    model(x);
    din = x;
    vin = 1'b1;
    @(posedge clk); #1;
    vin = 1'b0;
    repeat (gap - 1) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  always @(negedge clk) if (vld1) begin
    nvec++;
    assert (q1.size() > 0) else begin
      nerr++;
      $error("FAIL d1_spurious: got strobe want none");
    end
    if (q1.size() > 0) begin
      e1 = q1.pop_front();
      chk("d1_data", 32'(od1), 32'(e1.y));
      chk("d1_lat", cyc, e1.cyc);
    end
  end

  always @(negedge clk) if (vld2) begin
    nvec++;
    assert (q2.size() > 0) else begin
      nerr++;
      $error("FAIL d2_spurious: got strobe want none");
    end
    if (q2.size() > 0) begin
      e2 = q2.pop_front();
      chk("d2_data", 32'(od2), 32'(e2.y));
      chk("d2_lat", cyc, e2.cyc);
    end
  end

  initial begin
    logic [15:0] x;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_od1", 32'(od1), 32'h0);
    chk("rst_vld1", 32'(vld1), 32'h0);
    chk("rst_ovr1", 32'(ovr1), 32'h0);
    chk("rst_od2", 32'(od2), 32'h0);
    chk("rst_vld2", 32'(vld2), 32'h0);
    chk("rst_ovr2", 32'(ovr2), 32'h0);
    rst_n = 1'b1;
    idle(2);

    // impulse
    send(16'h7FFF, 20);
    for (int i = 0; i < 25; i++) send(16'h0000, 20);
    chk("imp_tail", 32'(od1), 32'h0);

    // DC
    for (int i = 0; i < 24; i++) send(16'h2000, 20);

    // saturation both rails
    for (int i = 0; i < 24; i++) send(16'h7FFF, 20);
    chk("sat_pos1", 32'(od1), 32'h7FFF);
    chk("sat_pos2", 32'(od2), 32'h7FFF);
    for (int i = 0; i < 24; i++) send(16'h8000, 20);
    chk("sat_neg1", 32'(od1), 32'h8000);
    chk("sat_neg2", 32'(od2), 32'h8000);

    // overrun: second strobe 3 clk after the first
    for (int i = 0; i < 4; i++) send(16'h0000, 20);
    send(16'h1234, 3);
    send(16'h4000, 20);
    send(16'h0F00, 3);
    send(16'hC000, 20);
    chk("ovr1", 32'(ovr1), 32'(ovr_m[0]));
    chk("ovr2", 32'(ovr2), 32'(ovr_m[1]));
    chk("ovr1_set", 32'(ovr1), 32'h1);
    for (int i = 0; i < 22; i++) send(16'(16'h0100 * i), 20);

    // reset at MAC k=5
    send(16'h0000, 20);
    send(16'h5555, 6);
    rst_n = 1'b0;
    model_reset();
    idle(3);
    chk("mrst_od1", 32'(od1), 32'h0);
    chk("mrst_vld1", 32'(vld1), 32'h0);
    chk("mrst_ovr1", 32'(ovr1), 32'h0);
    chk("mrst_od2", 32'(od2), 32'h0);
    chk("mrst_ovr2", 32'(ovr2), 32'h0);
    rst_n = 1'b1;
    idle(2);
    send(16'h7FFF, 20);
    for (int i = 0; i < 22; i++) send(16'h0000, 20);

    // random at minimum to relaxed spacing
    for (int i = 0; i < 300; i++) begin
      x = 16'($urandom);
      if (i % 37 == 0) x = 16'h7FFF;
      if (i % 41 == 0) x = 16'h8000;
      send(x, int'($urandom_range(13, 17)));
    end
    chk("rnd_ovr1", 32'(ovr1), 32'(ovr_m[0]));
    chk("rnd_ovr2", 32'(ovr2), 32'(ovr_m[1]));

    idle(30);
    chk("drain1", q1.size(), 0);
    chk("drain2", q2.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
